// File: rtl/tilemap_if.sv
// tilemap_if: bundles the tilemap scheduler's control, tilemap-memory and
// tile-drawer signals.
//   master : the scheduler (drives map_addr, drw_*, busy, done, tiles_drawn)
//   slave  : frame controller / tilemap RAM / tile drawer side
// Signals:
//   start         frame controller -> scheduler, one-cycle redraw request
//   map_addr      tilemap RAM read address (MAP_AW bits)
//   map_data      tile id, valid one cycle after map_addr
//   drw_draw      one-cycle draw request to the tile drawer
//   drw_tile_addr tile ROM base address (12 bits)
//   drw_x, drw_y  tile pixel origin
//   drw_active    tile drawer busy flag
//   busy, done    pass status toward the frame controller
//   tiles_drawn   draw requests issued in the current/last pass
interface tilemap_if #(
  parameter int MAP_AW = 9
);
  logic              start;
  logic [MAP_AW-1:0] map_addr;
  logic [7:0]        map_data;
  logic              drw_draw;
  logic [11:0]       drw_tile_addr;
  logic [7:0]        drw_x;
  logic [7:0]        drw_y;
  logic              drw_active;
  logic              busy;
  logic              done;
  logic [15:0]       tiles_drawn;

  modport master (
    input  start, map_data, drw_active,
    output map_addr, drw_draw, drw_tile_addr, drw_x, drw_y,
           busy, done, tiles_drawn
  );

  modport slave (
    output start, map_data, drw_active,
    input  map_addr, drw_draw, drw_tile_addr, drw_x, drw_y,
           busy, done, tiles_drawn
  );
endinterface

// File: rtl/tilemap_scheduler.sv
// tilemap_scheduler: walks a MAP_W x MAP_H grid of 8x8 tiles in raster order,
// reads each tile id from the tilemap RAM, converts it to a tile ROM base
// address and pixel origin, issues one draw request and waits for the drawer
// to finish before moving on.
// Ports:
//   clk     system clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     tilemap_if.master (start, map_addr/map_data, drw_*, busy, done,
//           tiles_drawn)
// Build option: define SKIP_BLANK_TILE_EN to treat tile id 8'h00 as
// transparent (no draw request, not counted).
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | map_addr presented to the tilemap RAM
// LATCH     | tile id valid; register ROM address and pixel origin
// ISSUE     | drw_draw high for one cycle, count the request
// WAIT_ACK  | wait up to ACK_WAIT cycles for drw_active to rise
// WAIT_DONE | wait for drw_active to fall
// ADVANCE   | step col/row/map_addr or finish
// DONE      | done pulse, busy drops next cycle
module tilemap_scheduler #(
  parameter int MAP_W      = 20,
  parameter int MAP_H      = 15,
  parameter int MAP_AW     = 9,
  parameter int TILE_BYTES = 192,
  parameter int ACK_WAIT   = 4
) (
  input  logic       clk,
  input  logic       resetn,
  tilemap_if.master  bus
);
  localparam int COL_W  = $clog2(MAP_W);
  localparam int ROW_W  = $clog2(MAP_H);
  localparam int ACK_CW = $clog2(ACK_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_ADVANCE, S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ACK_CW-1:0] ack_cnt;
  logic              last_col, last_row;

  assign last_col = (col == COL_W'(MAP_W - 1));
  assign last_row = (row == ROW_W'(MAP_H - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:      if (bus.start) state_nx = S_FETCH;
      S_FETCH:     state_nx = S_LATCH;
`ifdef SKIP_BLANK_TILE_EN
      S_LATCH:     state_nx = (bus.map_data == 8'h00) ? S_ADVANCE : S_ISSUE;
`else
      S_LATCH:     state_nx = S_ISSUE;
`endif
      S_ISSUE:     state_nx = S_WAIT_ACK;
      // An already-high drw_active on entry counts as the acknowledge; a
      // request that never gets acknowledged is dropped after ACK_WAIT cycles.
      S_WAIT_ACK: begin
        if (bus.drw_active)                         state_nx = S_WAIT_DONE;
        else if (ack_cnt == ACK_CW'(ACK_WAIT - 1))  state_nx = S_ADVANCE;
      end
      S_WAIT_DONE: if (!bus.drw_active) state_nx = S_ADVANCE;
      S_ADVANCE:   state_nx = (last_col && last_row) ? S_DONE : S_FETCH;
      S_DONE:      state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col               <= '0;
      row               <= '0;
      ack_cnt           <= '0;
      bus.map_addr      <= '0;
      bus.drw_draw      <= 1'b0;
      bus.drw_tile_addr <= '0;
      bus.drw_x         <= '0;
      bus.drw_y         <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.tiles_drawn   <= '0;
    end else begin
      bus.drw_draw <= (state_nx == S_ISSUE);
      bus.done     <= (state_nx == S_DONE);
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            col             <= '0;
            row             <= '0;
            bus.map_addr    <= '0;
            bus.tiles_drawn <= '0;
            bus.busy        <= 1'b1;
          end
        end
        S_LATCH: begin
          // Product formed in 16 bits, then truncated to the 12-bit ROM space.
          bus.drw_tile_addr <= 12'(16'(bus.map_data) * 16'(TILE_BYTES));
          bus.drw_x         <= 8'({col, 3'b000});
          bus.drw_y         <= 8'({row, 3'b000});
        end
        S_ISSUE: begin
          ack_cnt <= '0;
          if (bus.tiles_drawn != 16'hFFFF) bus.tiles_drawn <= bus.tiles_drawn + 16'd1;
        end
        S_WAIT_ACK: begin
          if (!bus.drw_active) ack_cnt <= ack_cnt + ACK_CW'(1);
        end
        S_ADVANCE: begin
          // map_addr tracks row*MAP_W+col incrementally, no multiplier needed.
          if (!(last_col && last_row)) begin
            bus.map_addr <= bus.map_addr + MAP_AW'(1);
            if (last_col) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        S_DONE: bus.busy <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tilemap_scheduler.sv
module tb_tilemap_scheduler;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  tilemap_if #(.MAP_AW(9)) bus ();

  tilemap_scheduler #(
    .MAP_W(20), .MAP_H(15), .MAP_AW(9), .TILE_BYTES(192), .ACK_WAIT(4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Synchronous tilemap RAM model: either addr[7:0] or the mem table.
  logic       use_mem = 1'b0;
  logic [7:0] mem [0:511];
  always @(posedge clk) bus.map_data <= use_mem ? mem[bus.map_addr] : bus.map_addr[7:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-pulse records from the last run_pass.
  int px [0:511];
  int py [0:511];
  int pa [0:511];
  int pm [0:511];
  int pc [0:511];
  int n_draw, n_done, pdone;
  bit timed_out;
  logic b0, b1;

  // mode 0: drawer raises active 0..2 cycles after the pulse and holds it
  // 1..200 cycles; mode 1: drawer never responds.
  // inject: extra start pulses at draw 10 and coincident with done.
  task automatic run_pass(input int mode, input bit inject);
    int rise, hold, post;
    bit pend, finished;
    n_draw = 0; n_done = 0; pdone = -1; timed_out = 0;
    rise = 0; hold = 0; post = -1; pend = 0; finished = 0;
    @(negedge clk);
    bus.start = 1'b1;
    b0 = bus.busy;
    @(negedge clk);
    bus.start = 1'b0;
    b1 = bus.busy;
    for (int g = 0; g < 30000; g++) begin
      bus.start = 1'b0;
      if (bus.drw_draw) begin
        if (n_draw < 512) begin
          px[n_draw] = int'(bus.drw_x);
          py[n_draw] = int'(bus.drw_y);
          pa[n_draw] = int'(bus.drw_tile_addr);
          pm[n_draw] = int'(bus.map_addr);
          pc[n_draw] = cyc;
        end
        n_draw++;
        if (mode == 0) begin
          pend = 1;
          rise = n_draw % 3;
          hold = (n_draw == 100) ? 200 : 2 + (n_draw * 37) % 19;
        end
        if (inject && n_draw == 10) bus.start = 1'b1;
      end
      if (pend) begin
        if (rise == 0) begin
          bus.drw_active = 1'b1;
          pend = 0;
        end else rise--;
      end else if (bus.drw_active) begin
        if (hold <= 1) bus.drw_active = 1'b0;
        else hold--;
      end
      if (bus.done) begin
        n_done++;
        if (pdone < 0) pdone = cyc;
        if (inject) bus.start = 1'b1;
        if (post < 0) post = 12;
      end
      if (post == 0) begin
        finished = 1;
        break;
      end
      if (post > 0) post--;
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.drw_active = 1'b0;
    timed_out = !finished;
  endtask

  task automatic test_reset;
    bit saw;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.drw_draw} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b expected 000", {bus.busy, bus.done, bus.drw_draw});
    end
    checks++;
    if (bus.map_addr !== 9'd0 || bus.tiles_drawn !== 16'd0) begin
      errors++; $display("FAIL reset_counts got addr %0d tiles %0d expected 0 0", bus.map_addr, bus.tiles_drawn);
    end
    checks++;
    if (bus.drw_tile_addr !== 12'd0 || bus.drw_x !== 8'd0 || bus.drw_y !== 8'd0) begin
      errors++; $display("FAIL reset_drw got %0d %0d %0d expected 0 0 0", bus.drw_tile_addr, bus.drw_x, bus.drw_y);
    end
    resetn = 1'b1;
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.drw_draw || bus.busy || bus.done) saw = 1;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++; $display("FAIL idle_quiet got activity %0d expected 0", saw);
    end
    checks++;
    if (bus.map_addr !== 9'd0 || bus.tiles_drawn !== 16'd0) begin
      errors++; $display("FAIL idle_counts got addr %0d tiles %0d expected 0 0", bus.map_addr, bus.tiles_drawn);
    end
  endtask

  task automatic test_full_pass;
    int bad;
    run_pass(0, 0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL full_timeout got timeout expected done"); end
    checks++;
    if (b0 !== 1'b0 || b1 !== 1'b1) begin
      errors++; $display("FAIL busy_rise got %b%b expected 01", b0, b1);
    end
    checks++;
    if (n_draw != 300) begin errors++; $display("FAIL full_draws got %0d expected 300", n_draw); end
    checks++;
    if (px[19] != 152 || py[19] != 0) begin
      errors++; $display("FAIL pulse20_xy got %0d,%0d expected 152,0", px[19], py[19]);
    end
    checks++;
    if (px[20] != 0 || py[20] != 8) begin
      errors++; $display("FAIL pulse21_xy got %0d,%0d expected 0,8", px[20], py[20]);
    end
    checks++;
    if (pa[3] != 576) begin errors++; $display("FAIL tile3_addr got %0d expected 576", pa[3]); end
    bad = 0;
    for (int k = 0; k < 300 && k < n_draw; k++) begin
      if (px[k] != (k % 20) * 8 || py[k] != (k / 20) * 8 ||
          pa[k] != (((k & 255) * 192) & 4095) || pm[k] != k) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL full_pulse_fields got %0d bad expected 0", bad); end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL full_done_count got %0d expected 1", n_done); end
    checks++;
    if (bus.tiles_drawn !== 16'd300 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL full_end got tiles %0d busy %b expected 300 0", bus.tiles_drawn, bus.busy);
    end
  endtask

  task automatic test_ack_timeout;
    int bad;
    run_pass(1, 0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL noack_timeout got timeout expected done"); end
    checks++;
    if (n_draw != 300) begin errors++; $display("FAIL noack_draws got %0d expected 300", n_draw); end
    bad = 0;
    for (int k = 1; k < 300 && k < n_draw; k++) if (pc[k] - pc[k-1] != 8) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL noack_gap got %0d bad gaps expected 0", bad); end
    checks++;
    if (n_done != 1 || bus.tiles_drawn !== 16'd300) begin
      errors++; $display("FAIL noack_end got done %0d tiles %0d expected 1 300", n_done, bus.tiles_drawn);
    end
    checks++;
    if (n_draw == 300 && pdone - pc[299] != 6) begin
      errors++; $display("FAIL done_latency got %0d expected 6", pdone - pc[299]);
    end
  endtask

  task automatic test_start_ignored;
    run_pass(1, 1);
    checks++;
    if (timed_out) begin errors++; $display("FAIL inject_timeout got timeout expected done"); end
    checks++;
    if (n_draw != 300 || n_done != 1) begin
      errors++; $display("FAIL inject_single_pass got draws %0d done %0d expected 300 1", n_draw, n_done);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.tiles_drawn !== 16'd300) begin
      errors++; $display("FAIL inject_end got busy %b tiles %0d expected 0 300", bus.busy, bus.tiles_drawn);
    end
  endtask

  task automatic test_reset_mid_pass;
    int draws;
    bit hit, saw;
    draws = 0; hit = 0; saw = 0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int g = 0; g < 5000; g++) begin
      if (bus.drw_draw) begin
        draws++;
        bus.drw_active = 1'b1;
        if (draws == 57) begin hit = 1; break; end
      end else if (bus.drw_active) bus.drw_active = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL abort_reach got draws %0d expected 57", draws); end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.tiles_drawn !== 16'd57) begin
      errors++; $display("FAIL abort_pre got busy %b tiles %0d expected 1 57", bus.busy, bus.tiles_drawn);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.map_addr !== 9'd0 || bus.tiles_drawn !== 16'd0) begin
      errors++; $display("FAIL abort_async got busy %b addr %0d tiles %0d expected 0 0 0", bus.busy, bus.map_addr, bus.tiles_drawn);
    end
    repeat (2) @(negedge clk);
    bus.drw_active = 1'b0;
    resetn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.drw_draw) saw = 1;
    end
    checks++;
    if (saw !== 1'b0) begin errors++; $display("FAIL abort_no_done got activity %0d expected 0", saw); end
    run_pass(1, 0);
    checks++;
    if (n_draw != 300 || pm[0] != 0 || px[0] != 0 || py[0] != 0) begin
      errors++; $display("FAIL abort_restart got draws %0d addr %0d x %0d y %0d expected 300 0 0 0", n_draw, pm[0], px[0], py[0]);
    end
  endtask

  task automatic test_blank_tiles;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[0] = 8'd5; mem[21] = 8'd1; mem[77] = 8'd3; mem[150] = 8'd7; mem[299] = 8'd255;
    use_mem = 1'b1;
    run_pass(0, 0);
    use_mem = 1'b0;
    checks++;
    if (timed_out || n_done != 1) begin
      errors++; $display("FAIL blank_done got timeout %0d done %0d expected 0 1", timed_out, n_done);
    end
`ifdef SKIP_BLANK_TILE_EN
    checks++;
    if (n_draw != 5 || bus.tiles_drawn !== 16'd5) begin
      errors++; $display("FAIL blank_count got draws %0d tiles %0d expected 5 5", n_draw, bus.tiles_drawn);
    end
    checks++;
    if (pm[1] != 21 || pm[2] != 77 || pa[2] != 576 || px[2] != 136 || py[2] != 24) begin
      errors++; $display("FAIL blank_cell got addr %0d rom %0d x %0d y %0d expected 77 576 136 24", pm[2], pa[2], px[2], py[2]);
    end
    checks++;
    if (pm[4] != 299 || pa[4] != 3904) begin
      errors++; $display("FAIL blank_trunc got addr %0d rom %0d expected 299 3904", pm[4], pa[4]);
    end
`else
    checks++;
    if (n_draw != 300 || bus.tiles_drawn !== 16'd300) begin
      errors++; $display("FAIL blank_count got draws %0d tiles %0d expected 300 300", n_draw, bus.tiles_drawn);
    end
    checks++;
    if (pa[1] != 0 || pa[21] != 192 || pa[77] != 576) begin
      errors++; $display("FAIL blank_rom got %0d %0d %0d expected 0 192 576", pa[1], pa[21], pa[77]);
    end
    checks++;
    if (pa[299] != 3904) begin errors++; $display("FAIL blank_trunc got %0d expected 3904", pa[299]); end
`endif
  endtask

  initial begin
    bus.start = 1'b0;
    bus.drw_active = 1'b0;
    test_reset();
    test_full_pass();
    test_ack_timeout();
    test_start_ignored();
    test_reset_mid_pass();
    test_blank_tiles();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
